// File: rtl/ps2_event_fifo_rx_if.sv
// Event bus between the PS/2 receiver and the CPU side: FIFO read handshake,
// interrupt pulse and status.
interface ps2_event_fifo_rx_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          rd_en;
  logic          clr_ovf;
  logic          evt_valid;
  logic [9:0]    evt_data;
  logic [CW-1:0] evt_count;
  logic          intrpt;
  logic          overflow;
  logic [7:0]    err_cnt;

  modport master (
    output rd_en, clr_ovf,
    input  evt_valid, evt_data, evt_count, intrpt, overflow, err_cnt
  );

  modport slave (
    input  rd_en, clr_ovf,
    output evt_valid, evt_data, evt_count, intrpt, overflow, err_cnt
  );
endinterface

// File: rtl/ps2_event_fifo_rx.sv
// PS/2 keyboard receiver: filtered clock, 11-bit frame check, E0/F0 prefix
// folding into 10-bit key events, show-ahead event FIFO and interrupt pulse.
module ps2_event_fifo_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int INTR_CYCLES    = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2clk,
  input  logic ps2data,
  ps2_event_fifo_rx_if.slave evt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = $clog2(INTR_CYCLES + 1);

  // Index 0 = PS2CLK, index 1 = PS2DATA; both idle high.
  logic [1:0] pin_meta_reg;
  logic [1:0] pin_sync_reg;
  logic       clk_s;
  logic       data_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_meta_reg <= 2'b11;
      pin_sync_reg <= 2'b11;
    end else begin
      pin_meta_reg <= {ps2data, ps2clk};
      pin_sync_reg <= pin_meta_reg;
    end
  end

  assign clk_s  = pin_sync_reg[0];
  assign data_s = pin_sync_reg[1];

  logic          filt_clk_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          filt_flip;
  logic          fall;

  // Counts consecutive samples that disagree with the filtered value.
  assign filt_flip = (clk_s != filt_clk_reg) && (filt_cnt_reg == FW'(FILTER_LEN - 1));
  assign fall      = filt_flip && filt_clk_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk_reg <= 1'b1;
      filt_cnt_reg <= '0;
    end else if (clk_s == filt_clk_reg) begin
      filt_cnt_reg <= '0;
    end else if (filt_flip) begin
      filt_clk_reg <= clk_s;
      filt_cnt_reg <= '0;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + 1'b1;
    end
  end

  typedef enum logic [1:0] {IDLE, RX, CHECK} state_t;

  state_t        state_reg, state_next;
  logic [10:0]   shift_reg;
  logic [3:0]    bitcnt_reg;
  logic [TW-1:0] wd_reg;
  logic          timeout;
  logic          frame_ok;
  logic          frame_err;
  logic          byte_valid;

  assign timeout  = (wd_reg == TW'(TIMEOUT_CYCLES - 1)) && !fall;
  assign frame_ok = shift_reg[10] && (^shift_reg[9:1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    frame_err  = 1'b0;
    byte_valid = 1'b0;
    case (state_reg)
      IDLE: if (fall && !data_s) state_next = RX;
      RX: begin
        if (fall && bitcnt_reg == 4'd10) begin
          state_next = CHECK;
        end else if (timeout) begin
          state_next = IDLE;
          frame_err  = 1'b1;
        end
      end
      CHECK: begin
        state_next = IDLE;
        if (frame_ok) byte_valid = 1'b1;
        else          frame_err  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame is shifted in LSB first: [0]=start, [8:1]=byte, [9]=parity, [10]=stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      bitcnt_reg <= '0;
      wd_reg     <= '0;
    end else begin
      if (fall && (state_reg == RX || (state_reg == IDLE && !data_s))) begin
        shift_reg <= {data_s, shift_reg[10:1]};
      end
      if (state_reg == IDLE && fall && !data_s) bitcnt_reg <= 4'd1;
      else if (state_reg == RX && fall)         bitcnt_reg <= bitcnt_reg + 4'd1;
      if (state_reg != RX || fall) wd_reg <= '0;
      else                         wd_reg <= wd_reg + 1'b1;
    end
  end

  logic       ext_reg;
  logic       brk_reg;
  logic [7:0] err_cnt_reg;
  logic       push;
  logic [9:0] push_data;

  assign push      = byte_valid && (shift_reg[8:1] != 8'hE0) && (shift_reg[8:1] != 8'hF0);
  assign push_data = {ext_reg, brk_reg, shift_reg[8:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_reg     <= 1'b0;
      brk_reg     <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      if (frame_err || push) begin
        ext_reg <= 1'b0;
        brk_reg <= 1'b0;
      end else if (byte_valid) begin
        if (shift_reg[8:1] == 8'hE0) ext_reg <= 1'b1;
        if (shift_reg[8:1] == 8'hF0) brk_reg <= 1'b1;
      end
      if (frame_err && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;
  logic [IW-1:0] intr_cnt_reg;
  logic          full;
  logic          pop;
  logic          do_push;

  assign full    = (count_reg == CW'(FIFO_DEPTH));
  assign pop     = evt.rd_en && (count_reg != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      intr_cnt_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !pop)      count_reg <= count_reg + 1'b1;
      else if (!do_push && pop) count_reg <= count_reg - 1'b1;
      if (push && !do_push) overflow_reg <= 1'b1;
      else if (evt.clr_ovf) overflow_reg <= 1'b0;
      if (do_push)                 intr_cnt_reg <= IW'(INTR_CYCLES);
      else if (intr_cnt_reg != '0) intr_cnt_reg <= intr_cnt_reg - 1'b1;
    end
  end

  assign evt.evt_valid = (count_reg != '0);
  assign evt.evt_data  = evt.evt_valid ? mem[rd_ptr_reg] : 10'h000;
  assign evt.evt_count = count_reg;
  assign evt.intrpt    = (intr_cnt_reg != '0);
  assign evt.overflow  = overflow_reg;
  assign evt.err_cnt   = err_cnt_reg;
endmodule

// File: tb/tb_ps2_event_fifo_rx.sv
// Randomised bench for ps2_event_fifo_rx against a byte/event-level queue model.
`timescale 1ns/1ps
module tb_ps2_event_fifo_rx;
  localparam int DEPTH = 8;
  localparam int INTR  = 6;
  localparam int TMO   = 1000;
  localparam int HALF  = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2clk = 1'b1;
  logic ps2data = 1'b1;

  always #5 clk = ~clk;

  ps2_event_fifo_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_event_fifo_rx #(
    .FILTER_LEN(8), .FIFO_DEPTH(DEPTH), .INTR_CYCLES(INTR), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ps2clk(ps2clk), .ps2data(ps2data), .evt(bus)
  );

  int n_checks = 0;
  int n_bad = 0;

  logic [9:0] mq[$];
  bit m_ext = 0, m_brk = 0, m_ovf = 0;
  int m_err = 0;
  int exp_pulses = 0;

  int pulses = 0, cur_width = 0, last_width = 0;

  always @(negedge clk) begin
    if (bus.intrpt) begin
      if (cur_width == 0) pulses++;
      cur_width++;
    end else if (cur_width != 0) begin
      last_width = cur_width;
      cur_width = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame-level reference: returns 1 when the event should land in the FIFO.
  function automatic bit model_frame(input logic [7:0] b, input bit good);
    logic [9:0] ev;
    if (!good) begin
      if (m_err < 255) m_err++;
      m_ext = 0;
      m_brk = 0;
      return 0;
    end
    if (b == 8'hE0) begin m_ext = 1; return 0; end
    if (b == 8'hF0) begin m_brk = 1; return 0; end
    ev = {m_ext, m_brk, b};
    m_ext = 0;
    m_brk = 0;
    if (mq.size() < DEPTH) begin
      mq.push_back(ev);
      exp_pulses++;
      return 1;
    end
    m_ovf = 1;
    return 0;
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2data = f[i];
      wait_cycles(5);
      ps2clk = 1'b0;
      wait_cycles(HALF);
      ps2clk = 1'b1;
      wait_cycles(HALF);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    send_bits(f, 11);
    ps2data = 1'b1;
    wait_cycles(40);
  endtask

  task automatic check_all(input string tag);
    logic [9:0] head;
    head = (mq.size() != 0) ? mq[0] : 10'h000;
    check({tag, "/count"}, 32'(bus.evt_count), mq.size());
    check({tag, "/valid"}, 32'(bus.evt_valid), (mq.size() != 0) ? 1 : 0);
    check({tag, "/data"}, 32'(bus.evt_data), 32'(head));
    check({tag, "/ovf"}, 32'(bus.overflow), 32'(m_ovf));
    check({tag, "/err"}, 32'(bus.err_cnt), m_err);
    check({tag, "/pulses"}, pulses, exp_pulses);
  endtask

  task automatic frame_and_check(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
    bit pushed;
    send_frame(b, bad_par, bad_stop);
    pushed = model_frame(b, !bad_par && !bad_stop);
    check_all(tag);
    if (pushed) check({tag, "/width"}, last_width, INTR);
  endtask

  task automatic pop_and_check(input string tag);
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
    check_all(tag);
  endtask

  task automatic clr_and_check(input string tag);
    @(negedge clk);
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    m_ovf = 0;
    check_all(tag);
  endtask

  initial begin
    logic [10:0] part;
    bus.rd_en = 1'b0;
    bus.clr_ovf = 1'b0;
    wait_cycles(5);
    check("rst_intr", 32'(bus.intrpt), 0);
    check_all("rst");
    rst_n = 1'b1;
    wait_cycles(5);
    check_all("post_rst");

    frame_and_check("make_1c", 8'h1C, 0, 0);
    pop_and_check("pop_1c");

    frame_and_check("e0", 8'hE0, 0, 0);
    frame_and_check("f0", 8'hF0, 0, 0);
    frame_and_check("ext_brk_75", 8'h75, 0, 0);
    check("ev_375", 32'(bus.evt_data), 32'h375);
    pop_and_check("pop_375");

    frame_and_check("bad_par", 8'h1C, 1, 0);
    frame_and_check("good_after_bad", 8'h1C, 0, 0);
    frame_and_check("e0_then_bad", 8'hE0, 0, 0);
    frame_and_check("bad_stop", 8'h1C, 0, 1);
    frame_and_check("no_prefix", 8'h1C, 0, 0);
    pop_and_check("pop_a");
    pop_and_check("pop_b");
    pop_and_check("pop_empty");

    for (int i = 0; i < 9; i++) frame_and_check("fill", 8'(8'h10 + i), 0, 0);
    clr_and_check("clr_ovf");
    for (int i = 0; i < DEPTH; i++) pop_and_check("drain");

    part = 11'b000_1011_0100;
    send_bits(part, 5);
    ps2data = 1'b1;
    wait_cycles(TMO + 200);
    void'(model_frame(8'h00, 0));
    check_all("timeout");
    frame_and_check("after_timeout", 8'h1C, 0, 0);
    pop_and_check("pop_to");

    @(negedge clk);
    ps2data = 1'b0;
    ps2clk = 1'b0;
    wait_cycles(3);
    ps2clk = 1'b1;
    ps2data = 1'b1;
    wait_cycles(30);
    check_all("glitch");
    frame_and_check("after_glitch", 8'h2A, 0, 0);

    for (int it = 0; it < 40; it++) begin
      int r, k, kind;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 25) begin
        pop_and_check("rnd_pop");
      end else if (r < 30) begin
        clr_and_check("rnd_clr");
      end else begin
        k = $urandom_range(0, 9);
        b = (k == 0) ? 8'hE0 : (k == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
        kind = $urandom_range(0, 11);
        frame_and_check("rnd_frame", b, kind == 0, kind == 1);
      end
    end

    send_bits(part, 4);
    @(negedge clk);
    rst_n = 1'b0;
    wait_cycles(2);
    check("rst_mid/count", 32'(bus.evt_count), 0);
    check("rst_mid/valid", 32'(bus.evt_valid), 0);
    check("rst_mid/data", 32'(bus.evt_data), 0);
    check("rst_mid/intr", 32'(bus.intrpt), 0);
    check("rst_mid/ovf", 32'(bus.overflow), 0);
    check("rst_mid/err", 32'(bus.err_cnt), 0);
    ps2clk = 1'b1;
    ps2data = 1'b1;
    mq.delete();
    m_ext = 0;
    m_brk = 0;
    m_ovf = 0;
    m_err = 0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(20);
    frame_and_check("after_rst", 8'h1C, 0, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
